// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: RV32I instruction fetch stage with IF/ID register, one-entry stall skid buffer and redirect flush
//   clk, rst_n              : core clock, synchronous active-low reset
//   stall, redirect         : hazard-unit hold of IF/ID, EX taken branch/jump (flushes and refetches)
//   redirect_pc             : redirect target, low two bits dropped
//   imem_req/addr/ack/rdata : fetch handshake, one request outstanding, addr is always the PC
//   ifid_valid/pc/inst      : registered IF/ID contents for decode, inst is NOP_INST when invalid
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_inst_q, ifid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d, skid_inst_q, skid_inst_d;
  logic ifid_valid_q, ifid_valid_d, fire, take, cap, drain, bubble;
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  always_comb begin
    fire = state_q == FETCH && imem_ack;
    take = fire && (!stall || !ifid_valid_q);
    // a completed fetch while decode is blocked parks in the skid buffer
    cap = fire && stall && ifid_valid_q;
    drain = state_q == HOLD && !stall;
    bubble = state_q == FETCH && !imem_ack && !stall;
  end
  always_ff @(posedge clk)
    if (!rst_n) state_q <= FETCH;
    else state_q <= state_d;
  always_comb
    state_d = redirect ? FETCH : cap ? HOLD : drain ? FETCH : state_q;
  always_comb begin
    imem_req = rst_n && state_q == FETCH;
    imem_addr = pc_q;
  end
  always_comb begin
    pc_d = redirect ? {redirect_pc[31:2], 2'b00} : fire ? pc_q + 32'd4 : pc_q;
    ifid_valid_d = (redirect || bubble) ? 1'b0 : (take || drain) ? 1'b1 : ifid_valid_q;
    ifid_pc_d = redirect ? 32'd0 : take ? pc_q : drain ? skid_pc_q : ifid_pc_q;
    ifid_inst_d = (redirect || bubble) ? NOP_INST : take ? imem_rdata : drain ? skid_inst_q : ifid_inst_q;
    skid_pc_d = (redirect || drain) ? 32'd0 : cap ? pc_q : skid_pc_q;
    skid_inst_d = (redirect || drain) ? 32'd0 : cap ? imem_rdata : skid_inst_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      pc_q <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q <= 32'd0;
      ifid_inst_q <= NOP_INST;
      skid_pc_q <= 32'd0;
      skid_inst_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q <= ifid_pc_d;
      ifid_inst_q <= ifid_inst_d;
      skid_pc_q <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  assign ifid_valid = ifid_valid_q;
  assign ifid_pc = ifid_pc_q;
  assign ifid_inst = ifid_inst_q;
endmodule

// File: tb/tb_fetch_ifid_stage.sv
// tb_fetch_ifid_stage: directed scenarios plus randomized run checked against an in-order fetch-stream model
module tb_fetch_ifid_stage;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0, hash = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic imem_req, ifid_valid;
  logic [31:0] imem_addr, imem_rdata, ifid_pc, ifid_inst;
  int n_cmp = 0, n_err = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a, input logic h);
    return h ? ((a * 32'h9E37_79B1) ^ 32'h0000_0013) : (a | 32'h0000_0013);
  endfunction
  assign imem_rdata = mem(imem_addr, hash);
  fetch_ifid_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_inst(ifid_inst)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    cyc();
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_inst", ifid_inst, NOP);
    chk("reset_valid", {31'd0, ifid_valid}, 32'd0);
    rst_n = 1'b1;
    chk("release_addr", imem_addr, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stream_pc", ifid_pc, 32'(i * 4));
      chk("stream_inst", ifid_inst, 32'(i * 4) | NOP);
      chk("stream_valid", {31'd0, ifid_valid}, 32'd1);
    end
  endtask
  task automatic test_stall_skid();
    do_reset();
    cyc(); cyc(); cyc();
    chk("pre_stall_pc", ifid_pc, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold_pc", ifid_pc, 32'h8);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    chk("stall_addr", imem_addr, 32'h10);
    stall = 1'b0;
    cyc();
    chk("skid_drain_pc", ifid_pc, 32'hC);
    chk("skid_drain_inst", ifid_inst, 32'h1F);
    cyc();
    chk("after_skid_pc", ifid_pc, 32'h10);
  endtask
  task automatic test_redirect_ack();
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    chk("pre_redir_addr", imem_addr, 32'h14);
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    cyc();
    redirect = 1'b0;
    chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
    chk("redir_inst", ifid_inst, NOP);
    chk("redir_addr", imem_addr, 32'h100);
    cyc();
    chk("redir_first_pc", ifid_pc, 32'h100);
    chk("redir_first_inst", ifid_inst, 32'h113);
  endtask
  task automatic test_redirect_hold();
    do_reset();
    cyc(); cyc(); cyc();
    stall = 1'b1;
    cyc();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    chk("hold_redir_req", {31'd0, imem_req}, 32'd1);
    chk("hold_redir_addr", imem_addr, 32'h200);
    chk("hold_redir_valid", {31'd0, ifid_valid}, 32'd0);
    cyc();
    chk("stall_empty_take", ifid_pc, 32'h200);
    stall = 1'b0;
  endtask
  task automatic test_ack_delay_wrap();
    logic [31:0] a0;
    do_reset();
    cyc();
    a0 = imem_addr;
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("delay_addr", imem_addr, a0);
      chk("delay_valid", {31'd0, ifid_valid}, 32'd0);
      chk("delay_inst", ifid_inst, NOP);
    end
    imem_ack = 1'b1;
    cyc();
    chk("delay_pc", ifid_pc, 32'h4);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", ifid_inst, 32'hFFFF_FFFF);
    chk("wrap_addr", imem_addr, 32'h0);
  endtask
  task automatic test_reset_in_hold();
    do_reset();
    cyc(); cyc(); cyc();
    stall = 1'b1;
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("rhold_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rhold_pc", ifid_pc, 32'd0);
    chk("rhold_inst", ifid_inst, NOP);
    rst_n = 1'b1; stall = 1'b0;
    chk("rhold_addr", imem_addr, 32'd0);
    cyc();
    chk("rhold_first", ifid_pc, 32'd0);
    cyc();
    chk("rhold_second", ifid_pc, 32'h4);
  endtask
  task automatic test_random();
    logic s, r, a, req, pv;
    logic [31:0] rp, paddr, ppc, pinst, exp_pc;
    int delivered = 0;
    hash = 1'b1;
    do_reset();
    exp_pc = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      stall = $urandom_range(0, 9) < 3;
      redirect = $urandom_range(0, 19) == 0;
      imem_ack = $urandom_range(0, 9) < 7;
      redirect_pc = $urandom;
      s = stall; r = redirect; a = imem_ack; rp = redirect_pc;
      req = imem_req; paddr = imem_addr; pv = ifid_valid; ppc = ifid_pc; pinst = ifid_inst;
      cyc();
      if (r) begin
        chk("rnd_redir_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rnd_redir_pc", ifid_pc, 32'd0);
        chk("rnd_redir_addr", imem_addr, rp & 32'hFFFF_FFFC);
        exp_pc = rp & 32'hFFFF_FFFC;
      end else begin
        if (!ifid_valid) chk("rnd_nop", ifid_inst, NOP);
        if (req && a) chk("rnd_addr_adv", imem_addr, paddr + 32'd4);
        else if (req) begin
          chk("rnd_addr_hold", imem_addr, paddr);
          chk("rnd_req_hold", {31'd0, imem_req}, 32'd1);
        end
        if (s && pv) begin
          chk("rnd_stall_valid", {31'd0, ifid_valid}, 32'd1);
          chk("rnd_stall_pc", ifid_pc, ppc);
          chk("rnd_stall_inst", ifid_inst, pinst);
        end else if (ifid_valid) begin
          chk("rnd_order_pc", ifid_pc, exp_pc);
          chk("rnd_order_inst", ifid_inst, mem(exp_pc, 1'b1));
          exp_pc += 32'd4;
          delivered++;
        end
      end
    end
    n_cmp++;
    if (delivered < 500) begin
      n_err++;
      $display("FAIL rnd_throughput: observed %0d deliveries expected at least 500", delivered);
    end
    stall = 1'b0; redirect = 1'b0; hash = 1'b0;
  endtask
  initial begin
    test_reset();
    test_stall_skid();
    test_redirect_ack();
    test_redirect_hold();
    test_ack_delay_wrap();
    test_reset_in_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the RV32I core.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Registers {pc, inst, valid} for decode; the immediate generator and register file consume ifid_inst directly.
- Supports hazard-unit stall (with a one-entry skid buffer) and branch/jump redirect from EX, with flush.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on ifid_inst when invalid.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  hazard unit: hold IF/ID contents this cycle.
- redirect  in  1  EX: taken branch/jump; flush and refetch.
- redirect_pc  in  32  target address for redirect.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address; always the PC register.
- imem_ack  in  1  memory returns imem_rdata this cycle; completes the request.
- imem_rdata  in  32  fetched instruction word.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  32  PC of ifid_inst.
- ifid_inst  out  32  instruction to decode; NOP_INST when ifid_valid=0.

Behaviour:
- Reset (rst_n=0 at edge):
  - pc=RESET_PC, state=FETCH.
  - ifid_valid=0, ifid_pc=0, ifid_inst=NOP_INST, skid empty.
  - imem_req=0 while rst_n=0 (combinational gate).
  - Reset mid-request abandons the request and ignores any ack.
- States: FETCH, HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - The request is held, with address stable, until imem_ack. The only exception is redirect, which changes the address; memory treats this as abandoning the request.
- FETCH, imem_ack=1, and (stall=0 or ifid_valid=0):
  - IF/ID <= {pc, imem_rdata, 1}.
  - pc <= pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  - Stay in FETCH. Back-to-back fetches give one instruction per cycle when imem_ack is held high.
- FETCH, imem_ack=1, stall=1, ifid_valid=1:
  - Skid <= {pc, imem_rdata}.
  - pc <= pc+4.
  - Go to HOLD. IF/ID is unchanged.
- FETCH, imem_ack=0: IF/ID unchanged if stall=1; if stall=0, ifid_valid <= 0 and ifid_inst <= NOP_INST (bubble).
- HOLD:
  - imem_req=0.
  - On stall=0: IF/ID <= {skid_pc, skid_inst, 1}, clear skid, go to FETCH. The next fetch request starts that same cycle's successor, so there is one cycle with no request.
  - On stall=1: remain in HOLD.
- Redirect (highest priority, any state, overrides stall and imem_ack):
  - pc <= {redirect_pc[31:2], 2'b00}; low bits are forced to zero.
  - ifid_valid <= 0, ifid_inst <= NOP_INST, ifid_pc <= 0.
  - Skid is cleared; state <= FETCH.
  - Any imem_rdata acked in the same cycle is discarded.
- Invariants:
  - ifid_inst == NOP_INST whenever ifid_valid == 0.
  - At most one request is outstanding.
  - Instructions reach IF/ID in strict PC order with no duplicates or losses.
  - All outputs are registered except imem_req and imem_addr, which are decoded from state and pc.

Test Plan:
- Reset release with imem_ack tied 1 and memory returning inst=addr|0x13: ifid_pc sequence is 0,4,8,C on consecutive cycles with ifid_valid=1. Before release, imem_req=0 and ifid_inst=0x00000013.
- Stall asserted for 3 cycles while imem_ack=1, IF/ID holding pc=8: IF/ID stays at 8 and the skid captures pc=C. The state is HOLD with imem_req=0. After stall drops, ifid_pc=C, then 0x10 follows; no instruction is lost or duplicated.
- Redirect to 0x0000_0102 in the same cycle as imem_ack for pc=0x14: the next cycle has ifid_valid=0, ifid_inst=0x13, imem_addr=0x100. The 0x14 data never appears on IF/ID.
- Redirect while in HOLD with stall=1: the skid is discarded, state=FETCH, imem_addr=redirect target, ifid_valid=0 despite stall.
- imem_ack delayed 2 cycles with stall=0: imem_addr is stable for 3 cycles and ifid_valid=0 for 2 cycles. Redirect pc=0xFFFF_FFFC followed by an ack gives next imem_addr=0x0000_0000.
- rst_n=0 asserted during HOLD with a full skid: the next cycle has pc=RESET_PC, ifid_valid=0, and the skid empty. An ack in the reset cycle is ignored.
